// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment display lab
// Cathode/anode patterns are active-low, cathode bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int BIN_W = 12;
  localparam int BCD_W = 16;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [3:0] ANODE_SEL [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (nib == 4'(i)) seg = SEG_DIGIT[i];
    end
    return seg;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// rtl/bcd_double_dabble.sv - sequential 12-bit binary to 4-digit BCD converter
// One add-3/shift step per cycle; result register holds until the next conversion.
module bcd_double_dabble
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  conv_state_e      state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] scr_q, scr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] adj;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          bin_d   = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = CONV_RUN;
        end
      end
      CONV_RUN: begin
        {scr_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        // Last shift lands straight in the output register, saving a cycle.
        if (cnt_q == 4'(BIN_W - 1)) begin
          bcd_d   = scr_d;
          done_d  = 1'b1;
          state_d = CONV_IDLE;
        end
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/top_multi_digit_display.sv
// rtl/top_multi_digit_display.sv - free-running decimal counter on a 4-digit 7-segment display
// Prescaler -> 12-bit counter -> double-dabble -> digit multiplexer/decoder.
module top_multi_digit_display
  import seg7_pkg::*;
#(
  parameter int COUNT_DIV   = 10_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] seg_cathode,
  output logic [3:0] seg_anode_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [RW-1:0]    ref_q, ref_d;
  logic [BIN_W-1:0] count_q, count_d;
  logic [1:0]       sel_q, sel_d;
  logic             start_q, start_d;
  logic             pend_q, pend_d;
  logic             tick, ref_wrap, conv_done;
  logic [BCD_W-1:0] bcd_w;
  logic [3:0]       nib;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      ref_q   <= '0;
      count_q <= '0;
      sel_q   <= '0;
      start_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      ref_q   <= ref_d;
      count_q <= count_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      pend_q  <= pend_d;
    end
  end

  assign tick     = (presc_q == PW'(COUNT_DIV - 1));
  assign ref_wrap = (ref_q == RW'(REFRESH_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    count_d = tick ? count_q + 1'b1 : count_q;
    ref_d   = ref_wrap ? '0 : ref_q + 1'b1;
    sel_d   = ref_wrap ? sel_q + 2'd1 : sel_q;
    // pend tracks an outstanding conversion so a start never hits a busy converter.
    start_d = tick & ~pend_q;
    pend_d  = (pend_q | start_q) & ~conv_done;
  end

  bcd_double_dabble u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_q),
    .bin   (count_q),
    .bcd   (bcd_w),
    .done  (conv_done)
  );

  assign nib         = 4'(bcd_w >> {sel_q, 2'b00});
  assign seg_cathode = seg_decode(nib);
  assign seg_anode_o = ANODE_SEL[sel_q];

endmodule

// File: tb/tb_top_multi_digit_display.sv
// tb/tb_top_multi_digit_display.sv - directed self-checking bench for the display top
// Digits are read by scanning 16 cycles and capturing the cathode per lit anode.
module tb_top_multi_digit_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_cathode;
  logic [3:0] seg_anode_o;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [3:0] AN [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int         n_tests = 0;
  int         n_fail  = 0;
  int         k;
  logic [6:0] dig [4];
  bit         mon_en = 1'b0;
  bit         done_seen = 1'b0;

  always #5 clk = ~clk;

  top_multi_digit_display #(.COUNT_DIV(20), .REFRESH_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_cathode (seg_cathode),
    .seg_anode_o (seg_anode_o)
  );

  always @(negedge clk) begin
    if (mon_en && dut.u_bcd.done) done_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic goto_k(input int t);
    while (k < t) step(1);
  endtask

  task automatic read_digits();
    for (int d = 0; d < 4; d++) dig[d] = 7'bx;
    repeat (16) begin
      step(1);
      case (seg_anode_o)
        4'b1110: dig[0] = seg_cathode;
        4'b1101: dig[1] = seg_cathode;
        4'b1011: dig[2] = seg_cathode;
        4'b0111: dig[3] = seg_cathode;
        default: ;
      endcase
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] th, input logic [6:0] hu,
                              input logic [6:0] te, input logic [6:0] on);
    chk({tag, ".thousands"}, 32'(dig[3]), 32'(th));
    chk({tag, ".hundreds"},  32'(dig[2]), 32'(hu));
    chk({tag, ".tens"},      32'(dig[1]), 32'(te));
    chk({tag, ".ones"},      32'(dig[0]), 32'(on));
  endtask

  initial begin
    reset = 1'b1;
    k = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_anode", 32'(seg_anode_o), 32'(4'b1110));
    chk("reset_cathode", 32'(seg_cathode), 32'(S0));

    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step(1);
      chk($sformatf("anode_seq_k%0d", k), 32'(seg_anode_o), 32'(AN[(k / 4) % 4]));
      chk("one_low", 32'($countones(~seg_anode_o)), 32'd1);
      chk("idle_zero", 32'(seg_cathode), 32'(S0));
    end

    goto_k(34);
    read_digits();
    check_digits("first_tick", S0, S0, S0, S1);

    goto_k(214);
    read_digits();
    check_digits("count10", S0, S0, S1, S0);

    goto_k(81914);
    read_digits();
    check_digits("count4095", S4, S0, S9, S5);

    goto_k(81934);
    read_digits();
    check_digits("wrap0", S0, S0, S0, S0);

    // Count 1 conversion is loaded at k=81941; interrupt it mid-shift.
    goto_k(81945);
    done_seen = 1'b0;
    mon_en = 1'b1;
    reset = 1'b1;
    step(2);
    chk("midreset_anode", 32'(seg_anode_o), 32'(4'b1110));
    chk("midreset_cathode", 32'(seg_cathode), 32'(S0));
    reset = 1'b0;
    k = 0;
    read_digits();
    chk("abort_no_done", 32'(done_seen), 32'd0);
    check_digits("after_reset", S0, S0, S0, S0);
    mon_en = 1'b0;

    goto_k(34);
    read_digits();
    check_digits("restart", S0, S0, S0, S1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
